uv_result_buffer: RTL and testbench
===================================

# uv_result_buffer

In-order result buffer at the output end of the two-lane ALU interface. Accepts up to two `uv_buff_s` result packets per cycle, one from ALU lane U and one from ALU lane V. Retires one result per cycle to the register-file write port. Provides youngest-match operand forwarding for two source registers to the issue stage.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; power of two, at least 2.

Ports (clock and reset first):
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_u_pkg`, in, `uv_buff_s`: lane-U result with fields `data_buff[31:0]`, `rd_addr[4:0]`, `fwd_en`, `valid`.
- `i_v_pkg`, in, `uv_buff_s`: lane-V result, same fields as lane U.
- `i_flush`, in, 1: discard all buffered and incoming results.
- `o_ready`, out, 1: buffer can accept two packets this cycle.
- `o_wb_en`, out, 1: register-file write enable.
- `o_wb_addr`, out, 5: register-file write address.
- `o_wb_data`, out, 32: register-file write data.
- `i_rs1_addr`, in, 5: forwarding query address, port 1.
- `i_rs2_addr`, in, 5: forwarding query address, port 2.
- `o_rs1_hit`, out, 1: forwarding hit, port 1.
- `o_rs1_data`, out, 32: forwarded data, port 1.
- `o_rs2_hit`, out, 1: forwarding hit, port 2.
- `o_rs2_data`, out, 32: forwarded data, port 2.

## Operation
- **Storage:** circular FIFO of `DEPTH` entries `{data, rd_addr, fwd_en}`.
  - Write pointer and read pointer are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
  - Occupancy count is `$clog2(DEPTH)+1` bits.
- **Push qualification:** a packet is pushed only when all of the following hold:
  - `valid=1`
  - `rd_addr!=0`
  - `o_ready=1`
  - `i_flush=0`

  Packets with `rd_addr=0` are dropped; x0 writes never occupy a slot.
- **Push ordering:** U is older than V.
  - Both qualify: U goes to `wptr`, V goes to `wptr+1`, and `wptr` advances by 2.
  - Only one qualifies: it goes to `wptr`, and `wptr` advances by 1.
- **Ready rule:** `o_ready = (DEPTH - count) >= 2`, computed from registered count only. A pop in the same cycle does not raise `o_ready`.
- **Protocol violation:** a push with `o_ready=0` is dropped, and a simulation assertion fires.
- **Retire:** when `count!=0` and `i_flush=0`:
  - `o_wb_en=1`, `o_wb_addr/o_wb_data` = head entry.
  - The head pops at the next edge.
  - When `count==0`: `o_wb_en=0`, and addr/data are 0.
- **Simultaneous push and pop:** `count_next = count + pushes - pop`, where pushes is 0–2 and pop is 0–1.
- **Forwarding:** each query port searches buffered entries only (not current-cycle inputs).
  - An entry matches when `fwd_en=1` and `rd_addr == rsN_addr`.
  - The youngest match, closest to `wptr`, wins.
  - `rsN_addr=0` never hits.
  - Miss: `hit=0`, `data=0`.
  - The entry currently on the writeback port is searchable.
- **Flush:** `i_flush=1`:
  - Forces `o_wb_en=0` and all hits to 0 combinationally in that cycle.
  - Drops incoming packets.
  - Resets pointers and count to 0 at the next edge.
  - Flush has priority over push and pop.
- **Reset:** asynchronous.
  - Pointers, count and entry valid state clear immediately.
  - Entry data/addr clear to 0.
  - Reset mid-stream loses all pending results; no partial writeback.

## Timing
- Reset values:
  - `o_ready=1`
  - `o_wb_en=0`, `o_wb_addr=0`, `o_wb_data=0`
  - `o_rs1_hit=0`, `o_rs2_hit=0`, `o_rs1_data=0`, `o_rs2_data=0`
- Push-to-writeback latency: 1 cycle into an empty buffer. A packet presented before edge E appears on `o_wb_*` in the cycle after E.
- Throughput: 1 retire per cycle. Sustained dual-lane input fills the buffer, and `o_ready` drops when 1 or 0 slots remain.
- Push-to-forward visibility: 1 cycle, same as writeback.
- Forwarding and writeback outputs are combinational from registered state plus `i_flush` and `i_rsN_addr`.

## Structure
- `aqua_pkg`:
  - holds `uv_buff_s`, unchanged;
  - adds constant `UV_BUFF_DEPTH = 4` and entry typedef `uv_entry_s {data, rd_addr, fwd_en}`.
- Sub-module `uv_fwd_lookup`: a priority search over `DEPTH` entries given `rptr`, `count` and query address. It returns hit and data, and is instantiated once per query port.

## Test plan
- **Reset:** assert `i_rst` mid-cycle → all outputs go to reset values without waiting for a clock edge; `o_ready=1`.
- **Single push:** U `{valid=1, rd=5, data=0x1234_5678}` for one cycle → next cycle `o_wb_en=1`, `o_wb_addr=5`, `o_wb_data=0x12345678`; the cycle after, `o_wb_en=0`.
- **Dual push with x0:**
  - Stimulus: U `{rd=3, 0xA}`, V `{rd=0, 0xB}` same cycle, then U `{rd=7, 0xC}`, V `{rd=7, 0xD}`.
  - Required retire order: 3/0xA, 7/0xC, 7/0xD; x0 never written.
  - `i_rs1_addr=7` hits with 0xD while both rd=7 entries are buffered.
- **Fill and wrap (DEPTH=4):**
  - Push two valid packets per cycle → `o_ready` deasserts when `count>=3`.
  - Continue until 12 packets are retired → retire order equals push order across pointer wrap; none lost or duplicated.
- **Forwarding gating:** buffered `{rd=9, fwd_en=0, 0x55}` → `i_rs2_addr=9` gives `hit=0`, `data=0`; `i_rs1_addr=0` gives `hit=0` regardless of contents.
- **Flush:** 3 entries buffered, assert `i_flush` with valid U/V inputs → `o_wb_en=0` that cycle; next cycle `count=0`, `o_wb_en=0`, and no hits.

Source files
------------

// File: rtl/aqua_pkg.sv
// Shared types for the two-lane ALU result path: lane packets and result-buffer entries.
package aqua_pkg;

    typedef struct packed {
        logic [31:0] data_buff;
        logic [4:0]  rd_addr;
        logic        fwd_en;
        logic        valid;
    } uv_buff_s;

    localparam int UV_BUFF_DEPTH = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd_addr;
        logic        fwd_en;
    } uv_entry_s;

endpackage

// File: rtl/uv_result_buffer_fwd_lookup.sv
// Youngest-match forwarding search over the occupied window [rptr, rptr+count) of the result FIFO.
module uv_fwd_lookup #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH*32-1:0]     data_flat,
    input  logic [DEPTH*5-1:0]      addr_flat,
    input  logic [DEPTH-1:0]        fwd_flat,
    input  logic [$clog2(DEPTH)-1:0] rptr,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic [4:0]              query,
    output logic                    hit,
    output logic [31:0]             data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx;

    // Walk oldest to youngest so the last match taken is the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr + PW'(i);
            if ((CW'(i) < count) && fwd_flat[idx] && (query != 5'd0) &&
                (addr_flat[int'(idx)*5 +: 5] == query)) begin
                hit  = 1'b1;
                data = data_flat[int'(idx)*32 +: 32];
            end
        end
    end

endmodule

// File: rtl/uv_result_buffer.sv
// In-order result buffer for ALU lanes U/V: dual push, single retire to the register file,
// and two-port youngest-match operand forwarding from buffered entries.
module uv_result_buffer
    import aqua_pkg::*;
#(
    parameter int DEPTH = UV_BUFF_DEPTH
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  uv_buff_s    i_u_pkg,
    input  uv_buff_s    i_v_pkg,
    input  logic        i_flush,
    output logic        o_ready,
    output logic        o_wb_en,
    output logic [4:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic        o_rs1_hit,
    output logic [31:0] o_rs1_data,
    output logic        o_rs2_hit,
    output logic [31:0] o_rs2_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    uv_entry_s     mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    logic [CW-1:0] free_slots;
    logic          u_req;
    logic          v_req;
    logic          u_push;
    logic          v_push;
    logic          pop;
    logic [PW-1:0] v_slot;

    logic [DEPTH*32-1:0] data_flat;
    logic [DEPTH*5-1:0]  addr_flat;
    logic [DEPTH-1:0]    fwd_flat;
    logic                rs1_hit_raw;
    logic                rs2_hit_raw;
    logic [31:0]         rs1_data_raw;
    logic [31:0]         rs2_data_raw;

    // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot early.
    assign free_slots = CW'(DEPTH) - count;
    assign o_ready    = (free_slots >= CW'(2));

    assign u_req  = i_u_pkg.valid && (i_u_pkg.rd_addr != 5'd0);
    assign v_req  = i_v_pkg.valid && (i_v_pkg.rd_addr != 5'd0);
    assign u_push = u_req && o_ready && !i_flush;
    assign v_push = v_req && o_ready && !i_flush;
    assign pop    = (count != '0) && !i_flush;
    assign v_slot = wptr + PW'(u_push);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (u_push) begin
                mem[wptr] <= '{data: i_u_pkg.data_buff, rd_addr: i_u_pkg.rd_addr,
                               fwd_en: i_u_pkg.fwd_en};
            end
            if (v_push) begin
                mem[v_slot] <= '{data: i_v_pkg.data_buff, rd_addr: i_v_pkg.rd_addr,
                                 fwd_en: i_v_pkg.fwd_en};
            end
            wptr  <= wptr + PW'(u_push) + PW'(v_push);
            rptr  <= rptr + PW'(pop);
            count <= count + CW'(u_push) + CW'(v_push) - CW'(pop);
        end
    end

    assign o_wb_en   = pop;
    assign o_wb_addr = pop ? mem[rptr].rd_addr : 5'd0;
    assign o_wb_data = pop ? mem[rptr].data : 32'd0;

    always_comb begin
        data_flat = '0;
        addr_flat = '0;
        fwd_flat  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            data_flat[i*32 +: 32] = mem[i].data;
            addr_flat[i*5 +: 5]   = mem[i].rd_addr;
            fwd_flat[i]           = mem[i].fwd_en;
        end
    end

    uv_fwd_lookup #(.DEPTH(DEPTH)) u_rs1_lookup (
        .data_flat (data_flat),
        .addr_flat (addr_flat),
        .fwd_flat  (fwd_flat),
        .rptr      (rptr),
        .count     (count),
        .query     (i_rs1_addr),
        .hit       (rs1_hit_raw),
        .data      (rs1_data_raw)
    );

    uv_fwd_lookup #(.DEPTH(DEPTH)) u_rs2_lookup (
        .data_flat (data_flat),
        .addr_flat (addr_flat),
        .fwd_flat  (fwd_flat),
        .rptr      (rptr),
        .count     (count),
        .query     (i_rs2_addr),
        .hit       (rs2_hit_raw),
        .data      (rs2_data_raw)
    );

    assign o_rs1_hit  = rs1_hit_raw && !i_flush;
    assign o_rs1_data = i_flush ? 32'd0 : rs1_data_raw;
    assign o_rs2_hit  = rs2_hit_raw && !i_flush;
    assign o_rs2_data = i_flush ? 32'd0 : rs2_data_raw;

    // Upstream must hold real results while the buffer reports not-ready.
    push_when_not_ready: assert property (@(posedge i_clk) disable iff (i_rst)
        !((u_req || v_req) && !o_ready && !i_flush));

endmodule

// File: tb/tb_uv_result_buffer.sv
// Randomized bench for uv_result_buffer against a queue-based reference model.
module tb_uv_result_buffer;
    import aqua_pkg::*;

    localparam int DEPTH = UV_BUFF_DEPTH;

    logic        i_clk;
    logic        i_rst;
    uv_buff_s    i_u_pkg;
    uv_buff_s    i_v_pkg;
    logic        i_flush;
    logic        o_ready;
    logic        o_wb_en;
    logic [4:0]  o_wb_addr;
    logic [31:0] o_wb_data;
    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic        o_rs1_hit;
    logic [31:0] o_rs1_data;
    logic        o_rs2_hit;
    logic [31:0] o_rs2_data;

    int errors = 0;
    int checks = 0;
    int retired = 0;
    int ready_low_seen = 0;

    uv_entry_s mq[$];

    uv_result_buffer #(.DEPTH(DEPTH)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_u_pkg    (i_u_pkg),
        .i_v_pkg    (i_v_pkg),
        .i_flush    (i_flush),
        .o_ready    (o_ready),
        .o_wb_en    (o_wb_en),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .i_rs1_addr (i_rs1_addr),
        .i_rs2_addr (i_rs2_addr),
        .o_rs1_hit  (o_rs1_hit),
        .o_rs1_data (o_rs1_data),
        .o_rs2_hit  (o_rs2_hit),
        .o_rs2_data (o_rs2_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic uv_buff_s pkt(input logic vld, input logic [4:0] rd,
                                     input logic [31:0] d, input logic fwd);
        uv_buff_s p;
        p.valid     = vld;
        p.rd_addr   = rd;
        p.data_buff = d;
        p.fwd_en    = fwd;
        return p;
    endfunction

    function automatic void model_fwd(input logic [4:0] a, input logic fl,
                                      output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'd0;
        if (!fl && a != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].fwd_en && mq[i].rd_addr == a) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                    break;
                end
            end
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
        check({tag, "_wb_en"}, 32'(o_wb_en), 32'd0);
        check({tag, "_wb_addr"}, 32'(o_wb_addr), 32'd0);
        check({tag, "_wb_data"}, o_wb_data, 32'd0);
        check({tag, "_rs1_hit"}, 32'(o_rs1_hit), 32'd0);
        check({tag, "_rs1_data"}, o_rs1_data, 32'd0);
        check({tag, "_rs2_hit"}, 32'(o_rs2_hit), 32'd0);
        check({tag, "_rs2_data"}, o_rs2_data, 32'd0);
    endtask

    // One cycle: drive at the falling edge, check 1ns later, then advance the model past the next rising edge.
    task automatic step(input uv_buff_s u, input uv_buff_s v, input logic fl,
                        input logic [4:0] a1, input logic [4:0] a2);
        logic        exp_ready;
        logic        h;
        logic [31:0] d;
        int          n;
        @(negedge i_clk);
        n = mq.size();
        exp_ready = ((DEPTH - n) >= 2);
        if (!exp_ready) begin
            u.valid = 1'b0;
            v.valid = 1'b0;
        end
        i_u_pkg    = u;
        i_v_pkg    = v;
        i_flush    = fl;
        i_rs1_addr = a1;
        i_rs2_addr = a2;
        #1;
        if (!exp_ready) ready_low_seen++;
        check("ready", 32'(o_ready), 32'(exp_ready));
        if (n > 0 && !fl) begin
            check("wb_en", 32'(o_wb_en), 32'd1);
            check("wb_addr", 32'(o_wb_addr), 32'(mq[0].rd_addr));
            check("wb_data", o_wb_data, mq[0].data);
        end else begin
            check("wb_en", 32'(o_wb_en), 32'd0);
            check("wb_addr", 32'(o_wb_addr), 32'd0);
            check("wb_data", o_wb_data, 32'd0);
        end
        model_fwd(a1, fl, h, d);
        check("rs1_hit", 32'(o_rs1_hit), 32'(h));
        check("rs1_data", o_rs1_data, d);
        model_fwd(a2, fl, h, d);
        check("rs2_hit", 32'(o_rs2_hit), 32'(h));
        check("rs2_data", o_rs2_data, d);
        if (o_wb_en) retired++;
        if (fl) begin
            mq.delete();
        end else begin
            if (n > 0) void'(mq.pop_front());
            if (u.valid && u.rd_addr != 5'd0)
                mq.push_back('{data: u.data_buff, rd_addr: u.rd_addr, fwd_en: u.fwd_en});
            if (v.valid && v.rd_addr != 5'd0)
                mq.push_back('{data: v.data_buff, rd_addr: v.rd_addr, fwd_en: v.fwd_en});
        end
    endtask

    function automatic logic [4:0] rand_rd();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd7 : 5'(r);
    endfunction

    initial begin : main
        uv_buff_s idle;
        int pushed;
        int fill_retired;
        idle = pkt(1'b0, 5'd0, 32'd0, 1'b0);
        i_rst      = 1'b1;
        i_u_pkg    = idle;
        i_v_pkg    = idle;
        i_flush    = 1'b0;
        i_rs1_addr = 5'd0;
        i_rs2_addr = 5'd0;
        #2;
        check_reset_outputs("por");
        @(negedge i_clk);
        i_rst = 1'b0;

        // Single push: one-cycle latency, then empty again.
        step(pkt(1'b1, 5'd5, 32'h1234_5678, 1'b1), idle, 1'b0, 5'd0, 5'd0);
        step(idle, idle, 1'b0, 5'd5, 5'd0);
        check("single_addr", 32'(o_wb_addr), 32'd5);
        check("single_data", o_wb_data, 32'h1234_5678);
        step(idle, idle, 1'b0, 5'd5, 5'd0);
        check("single_done", 32'(o_wb_en), 32'd0);

        // Dual push with an x0 lane, then two writes to the same register.
        step(pkt(1'b1, 5'd3, 32'hA, 1'b1), pkt(1'b1, 5'd0, 32'hB, 1'b1), 1'b0, 5'd0, 5'd0);
        step(pkt(1'b1, 5'd7, 32'hC, 1'b1), pkt(1'b1, 5'd7, 32'hD, 1'b1), 1'b0, 5'd0, 5'd0);
        step(idle, idle, 1'b0, 5'd7, 5'd0);
        check("dual_youngest", o_rs1_data, 32'hD);
        check("dual_first7", o_wb_data, 32'hC);
        step(idle, idle, 1'b0, 5'd7, 5'd7);
        step(idle, idle, 1'b0, 5'd0, 5'd0);

        // Fill and wrap with sustained dual-lane input.
        pushed = 0;
        retired = 0;
        ready_low_seen = 0;
        while (pushed < 12) begin
            if ((DEPTH - mq.size()) >= 2) begin
                step(pkt(1'b1, 5'(pushed % 30 + 1), 32'hF000 + 32'(pushed), 1'b1),
                     pkt(1'b1, 5'(pushed % 30 + 2), 32'hF000 + 32'(pushed + 1), 1'b1),
                     1'b0, 5'(pushed % 30 + 1), 5'd2);
                pushed += 2;
            end else begin
                step(idle, idle, 1'b0, 5'd1, 5'd2);
            end
        end
        for (int i = 0; i < 2 * DEPTH; i++) step(idle, idle, 1'b0, 5'd0, 5'd0);
        fill_retired = retired;
        check("fill_retired", 32'(fill_retired), 32'd12);
        check("fill_ready_dropped", 32'(ready_low_seen > 0), 32'd1);

        // Forwarding gating.
        step(pkt(1'b1, 5'd9, 32'h55, 1'b0), pkt(1'b1, 5'd4, 32'h44, 1'b1), 1'b0, 5'd0, 5'd0);
        step(idle, idle, 1'b0, 5'd0, 5'd9);
        check("gate_rs2_hit", 32'(o_rs2_hit), 32'd0);
        check("gate_rs1_x0", 32'(o_rs1_hit), 32'd0);
        step(idle, idle, 1'b0, 5'd4, 5'd0);
        step(idle, idle, 1'b0, 5'd0, 5'd0);

        // Flush with three entries buffered and live inputs.
        step(pkt(1'b1, 5'd1, 32'h11, 1'b1), pkt(1'b1, 5'd2, 32'h22, 1'b1), 1'b0, 5'd0, 5'd0);
        step(pkt(1'b1, 5'd3, 32'h33, 1'b1), pkt(1'b1, 5'd4, 32'h44, 1'b1), 1'b0, 5'd3, 5'd0);
        step(pkt(1'b1, 5'd5, 32'h55, 1'b1), pkt(1'b1, 5'd6, 32'h66, 1'b1), 1'b1, 5'd3, 5'd4);
        check("flush_wb_en", 32'(o_wb_en), 32'd0);
        check("flush_rs1_hit", 32'(o_rs1_hit), 32'd0);
        step(idle, idle, 1'b0, 5'd5, 5'd3);
        check("post_flush_wb_en", 32'(o_wb_en), 32'd0);
        check("post_flush_hit", 32'(o_rs1_hit | o_rs2_hit), 32'd0);

        // Asynchronous reset mid-stream.
        step(pkt(1'b1, 5'd8, 32'h88, 1'b1), pkt(1'b1, 5'd9, 32'h99, 1'b1), 1'b0, 5'd0, 5'd0);
        @(negedge i_clk);
        i_u_pkg    = idle;
        i_v_pkg    = idle;
        i_rs1_addr = 5'd8;
        i_rs2_addr = 5'd9;
        #2;
        i_rst = 1'b1;
        #1;
        check_reset_outputs("async");
        mq.delete();
        @(negedge i_clk);
        i_rst = 1'b0;
        step(idle, idle, 1'b0, 5'd8, 5'd9);

        // Randomized traffic.
        for (int c = 0; c < 500; c++) begin
            step(pkt($urandom_range(0, 3) != 0, rand_rd(), $urandom, $urandom_range(0, 3) != 0),
                 pkt($urandom_range(0, 3) != 0, rand_rd(), $urandom, $urandom_range(0, 3) != 0),
                 $urandom_range(0, 39) == 0, rand_rd(), rand_rd());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
